caliptra_prim_clock_sel_ctrl: RTL and testbench

- Synchronous controller that generalises a 2-input clock select to NumClk sources.
- It sequences break-before-make switching: all gate enables are dropped, the block waits OffCycles, enables exactly one source, then waits SettleCycles before acknowledging.
- Runs on an always-on control clock.
- en_o drives per-source clock gates whose outputs are ORed, so the downstream clock network never sees two sources enabled at once.

---
 rtl/caliptra_prim_clock_sel_pkg.sv | 15 +
 rtl/caliptra_prim_clock_sel_ctrl_if.sv | 23 ++
 rtl/caliptra_prim_clock_sel_ctrl.sv | 128 ++++++++++++
 tb/tb_caliptra_prim_clock_sel_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/caliptra_prim_clock_sel_pkg.sv
// Shared types for the N-way break-before-make clock select controller.
package caliptra_prim_clock_sel_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        ENABLE = 2'd2,
        DONE   = 2'd3
    } clk_sel_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/caliptra_prim_clock_sel_ctrl_if.sv
// Request/ack and gate-enable bundle between a requester and the clock select controller.
interface caliptra_prim_clock_sel_ctrl_if #(
    parameter int NumClk = 4,
    parameter int SelW   = $clog2(NumClk)
);
    logic              req_i;
    logic [SelW-1:0]   sel_i;
    logic              ack_o;
    logic              err_o;
    logic              busy_o;
    logic [NumClk-1:0] en_o;
    logic [SelW-1:0]   cur_sel_o;

    modport master (
        output req_i, sel_i,
        input  ack_o, err_o, busy_o, en_o, cur_sel_o
    );

    modport slave (
        input  req_i, sel_i,
        output ack_o, err_o, busy_o, en_o, cur_sel_o
    );
endinterface

// File: rtl/caliptra_prim_clock_sel_ctrl.sv
// Break-before-make select among NumClk gated clock sources: drop all enables,
// wait OffCycles, enable the target, wait SettleCycles, then acknowledge.
module caliptra_prim_clock_sel_ctrl
    import caliptra_prim_clock_sel_pkg::*;
#(
    parameter int NumClk       = 4,
    parameter int OffCycles    = 4,
    parameter int SettleCycles = 4,
    parameter int ResetSel     = 0,
    localparam int SelW        = $clog2(NumClk)
) (
    input logic clk_i,
    input logic rst_i,
    caliptra_prim_clock_sel_ctrl_if.slave bus
);

    localparam int CntW = $clog2(max_int(OffCycles, SettleCycles) + 1);

    if (NumClk < 2) begin : g_chk_numclk
        $error("NumClk must be at least 2");
    end
    if (OffCycles < 1) begin : g_chk_off
        $error("OffCycles must be at least 1");
    end
    if (SettleCycles < 1) begin : g_chk_settle
        $error("SettleCycles must be at least 1");
    end
    if ((ResetSel < 0) || (ResetSel >= NumClk)) begin : g_chk_resetsel
        $error("ResetSel must index a valid source");
    end

    function automatic logic [NumClk-1:0] onehot(input logic [SelW-1:0] idx);
        logic [NumClk-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

    clk_sel_state_e    state;
    logic [CntW-1:0]   cnt;
    logic [SelW-1:0]   tgt;
    logic [SelW-1:0]   cur_sel;
    logic [NumClk-1:0] en;
    logic              ack;
    logic              err;
    logic              sel_bad;

    // With a power-of-two source count every encodable index is valid.
    if ((1 << SelW) == NumClk) begin : g_all_valid
        assign sel_bad = 1'b0;
    end else begin : g_range_chk
        assign sel_bad = (bus.sel_i > SelW'(NumClk - 1));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            tgt     <= SelW'(ResetSel);
            cur_sel <= SelW'(ResetSel);
            en      <= onehot(SelW'(ResetSel));
            ack     <= 1'b0;
            err     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    ack <= 1'b0;
                    err <= 1'b0;
                    if (bus.req_i) begin
                        if (sel_bad) begin
                            state <= DONE;
                            ack   <= 1'b1;
                            err   <= 1'b1;
                        end else if (bus.sel_i == cur_sel) begin
                            state <= DONE;
                            ack   <= 1'b1;
                        end else begin
                            state <= DRAIN;
                            tgt   <= bus.sel_i;
                            en    <= '0;
                            cnt   <= CntW'(OffCycles - 1);
                        end
                    end
                end
                DRAIN: begin
                    if (cnt == '0) begin
                        state   <= ENABLE;
                        en      <= onehot(tgt);
                        cur_sel <= tgt;
                        cnt     <= CntW'(SettleCycles - 1);
                    end else begin
                        en  <= '0;
                        cnt <= cnt - 1'b1;
                    end
                end
                ENABLE: begin
                    if (cnt == '0) begin
                        state <= DONE;
                        ack   <= 1'b1;
                        err   <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    ack   <= 1'b0;
                    err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ack_o     = ack;
    assign bus.err_o     = err;
    assign bus.busy_o    = (state != IDLE);
    assign bus.en_o      = en;
    assign bus.cur_sel_o = cur_sel;

    a_en_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(en));
    a_drain_all_off: assert property (@(posedge clk_i) disable iff (rst_i)
        (state == DRAIN) |-> (en == '0));
    a_sel_known: assert property (@(posedge clk_i) disable iff (rst_i)
        bus.req_i |-> !$isunknown(bus.sel_i));

endmodule

// File: tb/tb_caliptra_prim_clock_sel_ctrl.sv
// Scoreboard bench: a 4-source and a 3-source controller share clock and reset.
module tb_caliptra_prim_clock_sel_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    caliptra_prim_clock_sel_ctrl_if #(.NumClk(4)) if4 ();
    caliptra_prim_clock_sel_ctrl_if #(.NumClk(3)) if3 ();

    caliptra_prim_clock_sel_ctrl #(.NumClk(4), .OffCycles(4), .SettleCycles(4), .ResetSel(0)) dut4 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if4.slave)
    );

    caliptra_prim_clock_sel_ctrl #(.NumClk(3), .OffCycles(4), .SettleCycles(4), .ResetSel(0)) dut3 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if3.slave)
    );

    typedef struct {
        int         cyc;
        logic       err;
        logic [1:0] cur;
        logic [3:0] en;
    } exp_t;

    exp_t q4[$];
    exp_t q3[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack4(input int bound);
        for (int i = 0; i < bound && if4.ack_o !== 1'b1; i++) tick();
        chk("ack4_timeout", {31'd0, if4.ack_o}, 32'd1);
    endtask

    // Real switch on the 4-source unit; optionally wiggle sel_i during DRAIN.
    task automatic switch4(input logic [1:0] s, input logic [1:0] old,
                           input bit glitch, input logic [1:0] gs);
        exp_t e;
        int   t;
        t   = cyc;
        e   = '{cyc: t + 9, err: 1'b0, cur: s, en: 4'(4'b0001 << s)};
        q4.push_back(e);
        if4.req_i = 1'b1;
        if4.sel_i = s;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (glitch && k == 2) if4.sel_i = gs;
            chk("sw_en",   {28'd0, if4.en_o},      (k <= 4) ? 32'd0 : {28'd0, 4'(4'b0001 << s)});
            chk("sw_cur",  {30'd0, if4.cur_sel_o}, (k <= 4) ? {30'd0, old} : {30'd0, s});
            chk("sw_busy", {31'd0, if4.busy_o},    32'd1);
        end
        wait_ack4(3);
        if4.req_i = 1'b0;
        tick();
        chk("sw_idle_busy", {31'd0, if4.busy_o}, 32'd0);
        chk("sw_idle_en",   {28'd0, if4.en_o},   {28'd0, 4'(4'b0001 << s)});
    endtask

    task automatic same4(input logic [1:0] s);
        exp_t e;
        e = '{cyc: cyc + 1, err: 1'b0, cur: s, en: 4'(4'b0001 << s)};
        q4.push_back(e);
        if4.req_i = 1'b1;
        if4.sel_i = s;
        tick();
        chk("same_busy", {31'd0, if4.busy_o}, 32'd1);
        chk("same_en",   {28'd0, if4.en_o},   {28'd0, 4'(4'b0001 << s)});
        wait_ack4(2);
        if4.req_i = 1'b0;
        tick();
        chk("same_idle_busy", {31'd0, if4.busy_o}, 32'd0);
        chk("same_idle_en",   {28'd0, if4.en_o},   {28'd0, 4'(4'b0001 << s)});
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            chk("onehot0_u4", {31'd0, $onehot0(if4.en_o)}, 32'd1);
            chk("onehot0_u3", {31'd0, $onehot0(if3.en_o)}, 32'd1);
        end
        if (if4.ack_o === 1'b1) begin
            if (q4.size() == 0) begin
                chk("ack4_unexpected", {31'd0, if4.ack_o}, 32'd0);
            end else begin
                e = q4.pop_front();
                chk("ack4_cycle", cyc, e.cyc);
                chk("ack4_err",   {31'd0, if4.err_o},     {31'd0, e.err});
                chk("ack4_cur",   {30'd0, if4.cur_sel_o}, {30'd0, e.cur});
                chk("ack4_en",    {28'd0, if4.en_o},      {28'd0, e.en});
            end
        end
        if (if3.ack_o === 1'b1) begin
            if (q3.size() == 0) begin
                chk("ack3_unexpected", {31'd0, if3.ack_o}, 32'd0);
            end else begin
                e = q3.pop_front();
                chk("ack3_cycle", cyc, e.cyc);
                chk("ack3_err",   {31'd0, if3.err_o},     {31'd0, e.err});
                chk("ack3_cur",   {30'd0, if3.cur_sel_o}, {30'd0, e.cur});
                chk("ack3_en",    {29'd0, if3.en_o},      {28'd0, e.en});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        if4.req_i = 1'b0;
        if4.sel_i = '0;
        if3.req_i = 1'b0;
        if3.sel_i = '0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        chk("rst_en4",   {28'd0, if4.en_o},      32'h1);
        chk("rst_cur4",  {30'd0, if4.cur_sel_o}, 32'h0);
        chk("rst_ack4",  {31'd0, if4.ack_o},     32'h0);
        chk("rst_busy4", {31'd0, if4.busy_o},    32'h0);
        chk("rst_en3",   {29'd0, if3.en_o},      32'h1);
        chk("rst_cur3",  {30'd0, if3.cur_sel_o}, 32'h0);

        repeat (5) tick();
        switch4(2'd2, 2'd0, 1'b0, 2'd0);
        repeat (2) tick();
        same4(2'd2);
        repeat (2) tick();
        switch4(2'd3, 2'd2, 1'b1, 2'd1);
        repeat (2) tick();

        // Out-of-range select on the 3-source unit is rejected in one cycle.
        e = '{cyc: cyc + 1, err: 1'b1, cur: 2'd0, en: 4'b0001};
        q3.push_back(e);
        if3.req_i = 1'b1;
        if3.sel_i = 2'd3;
        tick();
        chk("u3_busy", {31'd0, if3.busy_o},    32'd1);
        chk("u3_ack",  {31'd0, if3.ack_o},     32'd1);
        chk("u3_en",   {29'd0, if3.en_o},      32'h1);
        chk("u3_cur",  {30'd0, if3.cur_sel_o}, 32'h0);
        if3.req_i = 1'b0;
        tick();
        chk("u3_idle_busy", {31'd0, if3.busy_o},    32'd0);
        chk("u3_idle_en",   {29'd0, if3.en_o},      32'h1);
        chk("u3_idle_cur",  {30'd0, if3.cur_sel_o}, 32'h0);
        repeat (2) tick();

        // Reset while ENABLE is counting must abort with no ack.
        if4.req_i = 1'b1;
        if4.sel_i = 2'd1;
        repeat (6) tick();
        chk("abort_pre_en", {28'd0, if4.en_o}, 32'h2);
        rst = 1'b1;
        tick();
        chk("abort_en",   {28'd0, if4.en_o},      32'h1);
        chk("abort_cur",  {30'd0, if4.cur_sel_o}, 32'h0);
        chk("abort_busy", {31'd0, if4.busy_o},    32'h0);
        chk("abort_ack",  {31'd0, if4.ack_o},     32'h0);
        rst = 1'b0;
        if4.req_i = 1'b0;
        repeat (12) tick();
        chk("post_abort_en", {28'd0, if4.en_o}, 32'h1);

        switch4(2'd2, 2'd0, 1'b0, 2'd0);
        repeat (4) tick();

        chk("q4_drained", q4.size(), 32'd0);
        chk("q3_drained", q3.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
